div_iter_param: RTL

- Parametrised iterative integer divider for the RV32M execute stage, implementing DIV, DIVU, REM and REMU.
- Retires BITS_PER_CYCLE quotient bits per cycle using restoring division.
- Uses valid/ready handshakes on both input and output, carries an opaque tag, supports pipeline flush and early-out.
- Resolves RISC-V divide-by-zero and signed-overflow cases without iterating.

---
 rtl/div_pkg.sv | 43 ++++
 rtl/div_step.sv | 22 ++
 rtl/div_iter_param.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types, constants and special-case selection for the iterative divider.
// Widths up to XLEN_MAX are supported; instances slice the wide constants down.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_DIV,
    S_FIX,
    S_DONE
  } div_state_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_ONES,
    SEL_A,
    SEL_ZERO,
    SEL_SMIN
  } spec_sel_e;

  localparam int XLEN_MAX = 64;
  localparam logic [XLEN_MAX-1:0] ALL_ONES = '1;
  localparam logic [XLEN_MAX-1:0] SMIN_TOP = {1'b1, {(XLEN_MAX-1){1'b0}}};

  // Priority matters: divide-by-zero, then signed overflow, then early-out.
  function automatic spec_sel_e special_sel(input logic rem_sel, input logic b_zero,
                                            input logic ovf, input logic early);
    spec_sel_e sel;
    sel = SEL_NONE;
    if (b_zero)     sel = rem_sel ? SEL_A    : SEL_ONES;
    else if (ovf)   sel = rem_sel ? SEL_ZERO : SEL_SMIN;
    else if (early) sel = rem_sel ? SEL_A    : SEL_ZERO;
    return sel;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step.
// Zero latency; no flow control (pure datapath).
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   i_rem,
  input  logic            i_bit,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_qbit,
  output logic [XLEN:0]   o_rem
);

  logic [XLEN+1:0] w_shift;
  logic [XLEN+1:0] w_diff;

  // One extra bit beyond the partial remainder keeps the sign of the trial subtract.
  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {2'b00, i_divisor};
  assign o_qbit  = ~w_diff[XLEN+1];
  assign o_rem   = o_qbit ? w_diff[XLEN:0] : w_shift[XLEN:0];

endmodule

// File: rtl/div_iter_param.sv
// RV32M DIV/DIVU/REM/REMU iterative divider; XLEN/BITS_PER_CYCLE+2 cycles, 1 for special cases.
// Valid/ready on both sides; a held result stalls new requests until out_ready, flush aborts.
module div_iter_param
  import div_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int EARLY_OUT      = 1,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       div_op,
  input  logic [XLEN-1:0]  operand_a,
  input  logic [XLEN-1:0]  operand_b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  localparam int NSTEP = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(NSTEP);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(NSTEP - 1);
  localparam logic [XLEN-1:0]  L_ONES   = ALL_ONES[XLEN-1:0];
  localparam logic [XLEN-1:0]  L_SMIN   = SMIN_TOP[XLEN_MAX-1 -: XLEN];

  div_state_e       r_state;
  div_op_e          r_op;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [TAG_W-1:0] r_tag;
  logic [XLEN-1:0]  r_dvs;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN:0]    r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [XLEN-1:0]  r_result;
  logic [TAG_W-1:0] r_tag_out;
  logic             r_busy;

  // Special-case decode on the live request.
  logic            w_sgn;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_early;
  spec_sel_e       w_sel;
  logic [XLEN-1:0] w_spec_val;

  assign w_sgn    = ~div_op[0];
  assign w_a_abs  = (w_sgn && operand_a[XLEN-1]) ? -operand_a : operand_a;
  assign w_b_abs  = (w_sgn && operand_b[XLEN-1]) ? -operand_b : operand_b;
  assign w_b_zero = (operand_b == '0);
  assign w_ovf    = w_sgn && (operand_a == L_SMIN) && (operand_b == L_ONES);
  assign w_early  = (EARLY_OUT != 0) && (w_a_abs < w_b_abs);
  assign w_sel    = special_sel(div_op[1], w_b_zero, w_ovf, w_early);

  always_comb begin
    w_spec_val = '0;
    case (w_sel)
      SEL_ONES: w_spec_val = L_ONES;
      SEL_A:    w_spec_val = operand_a;
      SEL_SMIN: w_spec_val = L_SMIN;
      default:  w_spec_val = '0;
    endcase
  end

  // Absolute values of the captured operands; MIN maps to its unsigned magnitude.
  logic [XLEN-1:0] w_ra_abs;
  logic [XLEN-1:0] w_rb_abs;
  assign w_ra_abs = (!r_op[0] && r_a[XLEN-1]) ? -r_a : r_a;
  assign w_rb_abs = (!r_op[0] && r_b[XLEN-1]) ? -r_b : r_b;

  // Dividend bits shift out of r_quo MSB-first while quotient bits shift in at the bottom.
  logic [BITS_PER_CYCLE:0][XLEN:0]  w_rem_chain;
  logic [BITS_PER_CYCLE-1:0]        w_qbits;
  logic [XLEN-1:0]                  w_quo_next;

  assign w_rem_chain[0] = r_rem;

  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
    div_step #(.XLEN(XLEN)) u_step (
      .i_rem     (w_rem_chain[k]),
      .i_bit     (r_quo[XLEN-1-k]),
      .i_divisor (r_dvs),
      .o_qbit    (w_qbits[BITS_PER_CYCLE-1-k]),
      .o_rem     (w_rem_chain[k+1])
    );
  end

  if (BITS_PER_CYCLE == XLEN) begin : g_full
    assign w_quo_next = w_qbits;
  end else begin : g_part
    assign w_quo_next = {r_quo[XLEN-BITS_PER_CYCLE-1:0], w_qbits};
  end

  logic            w_q_neg;
  logic            w_r_neg;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;
  logic [XLEN-1:0] w_fixed;

  assign w_q_neg   = !r_op[0] && (r_a[XLEN-1] ^ r_b[XLEN-1]);
  assign w_r_neg   = !r_op[0] && r_a[XLEN-1];
  assign w_quo_fix = w_q_neg ? -r_quo : r_quo;
  assign w_rem_fix = w_r_neg ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
  assign w_fixed   = r_op[1] ? w_rem_fix : w_quo_fix;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= OP_DIV;
      r_a         <= '0;
      r_b         <= '0;
      r_tag       <= '0;
      r_dvs       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_tag_out   <= '0;
      r_busy      <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op   <= div_op_e'(div_op);
            r_a    <= operand_a;
            r_b    <= operand_b;
            r_tag  <= tag_in;
            r_busy <= 1'b1;
            if (w_sel != SEL_NONE) begin
              r_result    <= w_spec_val;
              r_tag_out   <= tag_in;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_PREP;
            end
          end
        end
        S_PREP: begin
          r_dvs   <= w_rb_abs;
          r_quo   <= w_ra_abs;
          r_rem   <= '0;
          r_cnt   <= CNT_INIT;
          r_state <= S_DIV;
        end
        S_DIV: begin
          r_rem <= w_rem_chain[BITS_PER_CYCLE];
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result    <= w_fixed;
          r_tag_out   <= r_tag;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = rst_n && !flush && (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign tag_out   = r_tag_out;
  assign busy      = r_busy;

endmodule
